// File: rtl/snake_pkg.sv
// Shared definitions for the snake head stepper: direction codes, FSM state
// encoding and default grid dimensions.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DEAD  = 2'b11
  } state_e;

  localparam int DEF_GRID_W = 40;
  localparam int DEF_GRID_H = 30;

endpackage

// File: rtl/snake_step_timer.sv
// Free-running step timer: counts enabled cycles and flags the terminal
// count with tick, wrapping to zero on that cycle.
module snake_step_timer #(
  parameter int STEP_CYCLES = 12500000,
  parameter int CNT_W       = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = enable && (cnt_q == CNT_W'(STEP_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head stepper: advances the head one cell per timer tick in the given
// direction and kills the snake at the walls. Build with SNAKE_WALL_WRAP_EN
// defined to wrap at the edges instead.
module snake_head_stepper
  import snake_pkg::*;
#(
  parameter int GRID_W      = DEF_GRID_W,
  parameter int GRID_H      = DEF_GRID_H,
  parameter int X_W         = 6,
  parameter int Y_W         = 5,
  parameter int STEP_CYCLES = 12500000,
  parameter int CNT_W       = 24,
  parameter int START_X     = 20,
  parameter int START_Y     = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           pause,
  input  logic [1:0]     direction,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic           step_valid,
  output logic [1:0]     step_dir,
  output logic           running,
  output logic           dead
);

  state_e         state_q, state_d;
  logic [X_W-1:0] head_x_q, head_x_d;
  logic [Y_W-1:0] head_y_q, head_y_d;
  logic           step_valid_q, step_valid_d;
  logic [1:0]     step_dir_q, step_dir_d;

  logic           tick;
  logic           load;
  logic           legal;
  logic [X_W-1:0] next_x;
  logic [Y_W-1:0] next_y;

  // A start pulse only (re)launches the game from IDLE or DEAD.
  assign load = start && ((state_q == ST_IDLE) || (state_q == ST_DEAD));

  snake_step_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (state_q == ST_RUN),
    .clear  (load),
    .tick   (tick)
  );

  // Edge tests come first so the decrement/increment never under- or overflows.
  always_comb begin
    next_x = head_x_q;
    next_y = head_y_q;
    legal  = 1'b1;
    case (dir_e'(direction))
      DIR_UP: begin
        if (head_y_q == '0) begin
`ifdef SNAKE_WALL_WRAP_EN
          next_y = Y_W'(GRID_H - 1);
`else
          legal  = 1'b0;
`endif
        end else begin
          next_y = head_y_q - 1'b1;
        end
      end
      DIR_DOWN: begin
        if (head_y_q == Y_W'(GRID_H - 1)) begin
`ifdef SNAKE_WALL_WRAP_EN
          next_y = '0;
`else
          legal  = 1'b0;
`endif
        end else begin
          next_y = head_y_q + 1'b1;
        end
      end
      DIR_LEFT: begin
        if (head_x_q == '0) begin
`ifdef SNAKE_WALL_WRAP_EN
          next_x = X_W'(GRID_W - 1);
`else
          legal  = 1'b0;
`endif
        end else begin
          next_x = head_x_q - 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (head_x_q == X_W'(GRID_W - 1)) begin
`ifdef SNAKE_WALL_WRAP_EN
          next_x = '0;
`else
          legal  = 1'b0;
`endif
        end else begin
          next_x = head_x_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    head_x_d     = head_x_q;
    head_y_d     = head_y_q;
    step_dir_d   = step_dir_q;
    step_valid_d = 1'b0;
    if (load) begin
      head_x_d = X_W'(START_X);
      head_y_d = Y_W'(START_Y);
    end else if (tick && legal) begin
      head_x_d     = next_x;
      head_y_d     = next_y;
      step_dir_d   = direction;
      step_valid_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (tick && !legal) begin
          state_d = ST_DEAD;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: if (!pause) state_d = ST_RUN;
      ST_DEAD:  if (start) state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      head_x_q     <= X_W'(START_X);
      head_y_q     <= Y_W'(START_Y);
      step_valid_q <= 1'b0;
      step_dir_q   <= 2'b11;
    end else begin
      state_q      <= state_d;
      head_x_q     <= head_x_d;
      head_y_q     <= head_y_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
    end
  end

  always_comb begin
    running    = (state_q == ST_RUN);
    dead       = (state_q == ST_DEAD);
    head_x     = head_x_q;
    head_y     = head_y_q;
    step_valid = step_valid_q;
    step_dir   = step_dir_q;
  end

endmodule

// File: tb/tb_snake_head_stepper.sv
// Directed bench for snake_head_stepper on an 8x6 grid with a 4-cycle step.
module tb_snake_head_stepper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] direction = 2'b11;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic       step_valid;
  logic [1:0] step_dir;
  logic       running;
  logic       dead;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0;

  typedef struct {
    int x;
    int y;
    int dir;
    int cyc;
  } exp_t;
  exp_t sb[$];

  snake_head_stepper #(
    .GRID_W      (8),
    .GRID_H      (6),
    .X_W         (6),
    .Y_W         (5),
    .STEP_CYCLES (4),
    .CNT_W       (24),
    .START_X     (4),
    .START_Y     (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .direction  (direction),
    .head_x     (head_x),
    .head_y     (head_y),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .running    (running),
    .dead       (dead)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic push(input int x, input int y, input int d, input int c);
    exp_t e;
    e.x = x; e.y = y; e.dir = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] d, output int c);
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    direction = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, int'(head_x), 4);
    check({tag, "_y"}, int'(head_y), 3);
    check({tag, "_sv"}, int'(step_valid), 0);
    check({tag, "_dir"}, int'(step_dir), 3);
    check({tag, "_run"}, int'(running), 0);
    check({tag, "_dead"}, int'(dead), 0);
  endtask

  // Scoreboard monitor: every step_valid must match the next expected step.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (step_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_step", 1, 0);
        end else begin
          e = sb.pop_front();
          check("step_x", int'(head_x), e.x);
          check("step_y", int'(head_y), e.y);
          check("step_dir", int'(step_dir), e.dir);
          check("step_cyc", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    // Reset held, then idle without start.
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    rst = 1'b1;
    repeat (50) @(negedge clk);
    check_reset_vals("idle50");

    // Straight down into the bottom wall.
    pulse_start(2'b11, c0);
    push(4, 4, 3, c0 + 5);
    push(4, 5, 3, c0 + 9);
`ifdef SNAKE_WALL_WRAP_EN
    push(4, 0, 3, c0 + 13);
`endif
    wait_until(c0 + 12);
    check("down_running", int'(running), 1);
    check("down_dead_early", int'(dead), 0);
    wait_until(c0 + 13);
`ifdef SNAKE_WALL_WRAP_EN
    check("down_wrap_dead", int'(dead), 0);
    check("down_wrap_y", int'(head_y), 0);
`else
    check("down_dead", int'(dead), 1);
    check("down_running_off", int'(running), 0);
    check("down_held_y", int'(head_y), 5);
    check("down_held_x", int'(head_x), 4);
`endif
    wait_until(c0 + 16);
    check("down_sb_empty", sb.size(), 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Direction only sampled on the tick cycle; start ignored while running.
    pulse_start(2'b10, c0);
    push(5, 3, 2, c0 + 5);
    push(6, 3, 2, c0 + 9);
    direction = 2'b00;
    wait_until(c0 + 2); direction = 2'b10;
    wait_until(c0 + 3); direction = 2'b00;
    wait_until(c0 + 4); direction = 2'b10;
    wait_until(c0 + 5); direction = 2'b01;
    wait_until(c0 + 6); start = 1'b1;
    wait_until(c0 + 7); start = 1'b0; direction = 2'b00;
    wait_until(c0 + 8); direction = 2'b10;
    wait_until(c0 + 10);
    check("toggle_running", int'(running), 1);
    // Asynchronous reset between clock edges.
    #2 rst = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_x", int'(head_x), 4);
    check("post_rst_run", int'(running), 0);
    check("toggle_sb_empty", sb.size(), 0);

    // Left with a 10-cycle pause mid-period, then into the left wall.
    pulse_start(2'b01, c0);
    push(3, 3, 1, c0 + 5);
    push(2, 3, 1, c0 + 9);
    wait_until(c0 + 10); pause = 1'b1;
    wait_until(c0 + 15);
    check("pause_running", int'(running), 0);
    check("pause_x", int'(head_x), 2);
    wait_until(c0 + 20); pause = 1'b0;
    push(1, 3, 1, c0 + 23);
    push(0, 3, 1, c0 + 27);
`ifdef SNAKE_WALL_WRAP_EN
    push(7, 3, 1, c0 + 31);
`endif
    wait_until(c0 + 22);
    check("resume_x", int'(head_x), 2);
    check("resume_running", int'(running), 1);
    wait_until(c0 + 31);
`ifdef SNAKE_WALL_WRAP_EN
    check("wrap_dead", int'(dead), 0);
    check("wrap_x", int'(head_x), 7);
`else
    check("left_dead", int'(dead), 1);
    check("left_held_x", int'(head_x), 0);
`endif
    wait_until(c0 + 34);
    check("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
